// File: rtl/result_uart_tx.sv
// result_uart_tx: serial transmitter for datapath results.
// Sends one DATAWIDTH-bit value per 8N1-style frame on sTx, LSB first, and reports
// busy/done/overrun status. Defining RESULT_UART_TX_PARITY_EN adds an even parity bit
// between the data bits and the stop bit.
module result_uart_tx #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD      = 115200
) (
  input  logic                 clk,
  input  logic                 lowRst,
  input  logic                 lowWr,
  input  logic [DATAWIDTH-1:0] DataIn,
  output logic                 sTx,
  output logic                 sBusy,
  output logic                 sDone,
  output logic                 sOverrun
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = $clog2(DATAWIDTH);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATAWIDTH - 1);

  // Reject configurations that cannot time a bit or frame correctly.
  if (CLKS_PER_BIT < 2) begin : gBadBaud
    $error("result_uart_tx: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATAWIDTH < 5 || DATAWIDTH > 8) begin : gBadWidth
    $error("result_uart_tx: DATAWIDTH must be in 5..8");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef RESULT_UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } stateT;

  stateT                state;
  logic [DATAWIDTH-1:0] shiftReg;
  logic [BitW-1:0]      bitCnt;
  logic [BaudW-1:0]     baudCnt;
  logic                 bitEnd;
`ifdef RESULT_UART_TX_PARITY_EN
  logic                 parityBit;
`endif

  // Last cycle of the current bit period.
  always_comb begin
    bitEnd = (baudCnt == BaudLast);
  end

  // Frame sequencer; every output is driven from this register block.
  always_ff @(posedge clk) begin
    if (!lowRst) begin
      state    <= StIdle;
      shiftReg <= '0;
      bitCnt   <= '0;
      baudCnt  <= '0;
      sTx      <= 1'b1;
      sBusy    <= 1'b0;
      sDone    <= 1'b0;
      sOverrun <= 1'b0;
`ifdef RESULT_UART_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      sDone <= 1'b0;
      // A load strobe during a frame is dropped but remembered until reset.
      if (!lowWr && state != StIdle) begin
        sOverrun <= 1'b1;
      end
      // Baud counter restarts at every bit boundary and is held at zero when idle.
      if (state == StIdle || bitEnd) begin
        baudCnt <= '0;
      end else begin
        baudCnt <= baudCnt + 1'b1;
      end

      case (state)
        StIdle: begin
          if (!lowWr) begin
            shiftReg <= DataIn;
            bitCnt   <= '0;
            sTx      <= 1'b0;
            sBusy    <= 1'b1;
            state    <= StStart;
`ifdef RESULT_UART_TX_PARITY_EN
            parityBit <= ^DataIn;
`endif
          end
        end
        StStart: begin
          if (bitEnd) begin
            sTx   <= shiftReg[0];
            state <= StData;
          end
        end
        StData: begin
          if (bitEnd) begin
            if (bitCnt == BitLast) begin
`ifdef RESULT_UART_TX_PARITY_EN
              sTx   <= parityBit;
              state <= StParity;
`else
              sTx   <= 1'b1;
              state <= StStop;
`endif
            end else begin
              // Present the next bit in the same edge that shifts it into position 0.
              shiftReg <= shiftReg >> 1;
              sTx      <= shiftReg[1];
              bitCnt   <= bitCnt + 1'b1;
            end
          end
        end
`ifdef RESULT_UART_TX_PARITY_EN
        StParity: begin
          if (bitEnd) begin
            sTx   <= 1'b1;
            state <= StStop;
          end
        end
`endif
        StStop: begin
          if (bitEnd) begin
            sBusy <= 1'b0;
            sDone <= 1'b1;
            state <= StIdle;
          end
        end
        default: begin
          sTx   <= 1'b1;
          sBusy <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Testbench for result_uart_tx: stimulus pushes expected bytes into a queue, a monitor
// captures each frame from sTx and compares it with a slot-level line model.
`timescale 1ns/1ps
module tb_result_uart_tx;

  localparam int W = 8;
  localparam int C = 4;
`ifdef RESULT_UART_TX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif

  logic       clk = 1'b0;
  logic       lowRst = 1'b0;
  logic       lowWr = 1'b1;
  logic [7:0] DataIn = 8'h00;
  logic       sTx, sBusy, sDone, sOverrun;

  int checks = 0;
  int failures = 0;
  int idleErrs = 0;
  logic [7:0] expQ[$];

  result_uart_tx #(
    .DATAWIDTH(W),
    .CLK_FREQ (40),
    .BAUD     (10)
  ) dut (
    .clk     (clk),
    .lowRst  (lowRst),
    .lowWr   (lowWr),
    .DataIn  (DataIn),
    .sTx     (sTx),
    .sBusy   (sBusy),
    .sDone   (sDone),
    .sOverrun(sOverrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line level in bit slot `slot` of a frame carrying b.
  function automatic logic lineBit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= W) return b[slot-1];
`ifdef RESULT_UART_TX_PARITY_EN
    if (slot == W + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  // Monitor: collect sTx while busy, judge the frame when sDone pulses.
  logic       samp [0:63];
  int         nSamp = 0;
  logic       prevDone = 1'b0;
  logic [7:0] monExp;
  logic [7:0] monGot;
  int         monBad;

  always @(negedge clk) begin
    if (!lowRst) begin
      nSamp = 0;
      prevDone = 1'b0;
    end else begin
      if (!sBusy && sTx !== 1'b1) idleErrs++;
      if (sBusy) begin
        if (nSamp < 64) samp[nSamp] = sTx;
        nSamp++;
      end
      if (sDone) begin
        chk("done_one_cycle", int'(prevDone), 0);
        chk("done_busy_low", int'(sBusy), 0);
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame_unexpected: got a frame of %0d cycles, expected none", nSamp);
        end else begin
          monExp = expQ.pop_front();
          monBad = 0;
          monGot = 8'h00;
          for (int i = 0; i < nSamp && i < 64; i++) begin
            if (samp[i] !== lineBit(monExp, i / C)) monBad++;
          end
          for (int k = 0; k < W; k++) monGot[k] = samp[(k + 1) * C + C / 2];
          chk("frame_len", nSamp, NB * C);
          chk("frame_data", int'(monGot), int'(monExp));
          chk("frame_shape_errs", monBad, 0);
        end
        nSamp = 0;
      end
      prevDone = sDone;
    end
  end

  task automatic tick();
    @(negedge clk);
    if (lowWr) DataIn = 8'($urandom);
  endtask

  // Load b on the next rising edge; returns at the negedge after the load edge.
  task automatic load(input logic [7:0] b);
    lowWr = 1'b0;
    DataIn = b;
    expQ.push_back(b);
    @(negedge clk);
    lowWr = 1'b1;
    DataIn = 8'($urandom);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (sBusy && n < 200) begin
      tick();
      n++;
    end
    chk(name, int'(n < 200), 1);
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!sDone && n < 200) begin
      tick();
      n++;
    end
    chk(name, int'(n < 200), 1);
  endtask

  task automatic overrunPulse(input logic [7:0] b);
    lowWr = 1'b0;
    DataIn = b;
    @(negedge clk);
    lowWr = 1'b1;
  endtask

  bit anyPulse = 1'b0;

  initial begin
    // Reset values
    lowRst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(sTx), 1);
    chk("rst_busy", int'(sBusy), 0);
    chk("rst_done", int'(sDone), 0);
    chk("rst_overrun", int'(sOverrun), 0);
    lowRst = 1'b1;
    repeat (2) tick();

    // Single frame
    load(8'hA5);
    chk("load_tx_low", int'(sTx), 0);
    chk("load_busy", int'(sBusy), 1);
    waitIdle("a5_timeout");
    chk("a5_done", int'(sDone), 1);
    repeat (3) tick();

    // Back-to-back: second load in the sDone cycle starts immediately
    load(8'h00);
    waitDone("b2b_done_timeout");
    load(8'hFF);
    chk("b2b_start_tx", int'(sTx), 0);
    chk("b2b_start_busy", int'(sBusy), 1);
    waitIdle("b2b_timeout");
    repeat (3) tick();

    // Overrun: strobe at cycle 10 of the frame is ignored for data
    load(8'h3C);
    chk("ovr_before", int'(sOverrun), 0);
    repeat (9) tick();
    overrunPulse(8'hFF);
    chk("ovr_set", int'(sOverrun), 1);
    waitIdle("ovr_timeout");
    repeat (3) tick();
    chk("ovr_sticky", int'(sOverrun), 1);

    // Reset mid-frame aborts with no sDone
    load(8'h81);
    repeat (14) tick();
    lowRst = 1'b0;
    expQ.delete();
    tick();
    chk("midrst_tx", int'(sTx), 1);
    chk("midrst_busy", int'(sBusy), 0);
    chk("midrst_done", int'(sDone), 0);
    chk("midrst_overrun", int'(sOverrun), 0);
    lowRst = 1'b1;
    repeat (5) tick();
    load(8'h42);
    waitIdle("x42_timeout");
    tick();
    load(8'h07);
    waitIdle("x07_timeout");

    // Randomised traffic with gaps, back-to-back loads and ignored strobes
    load(8'($urandom));
    for (int it = 0; it < 24; it++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 30)) tick();
        overrunPulse(8'($urandom));
        anyPulse = 1'b1;
      end
      if (gap == 0) begin
        waitDone("rnd_done_timeout");
      end else begin
        waitIdle("rnd_idle_timeout");
        repeat (gap) tick();
      end
      load(8'($urandom));
    end
    waitIdle("rnd_last_timeout");
    chk("rnd_overrun", int'(sOverrun), int'(anyPulse));

    for (int n = 0; n < 100 && expQ.size() > 0; n++) tick();
    chk("queue_drained", expQ.size(), 0);
    chk("idle_line_low", idleErrs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
